// File: rtl/bios_loader_if.sv
// ROM read port, memory write port and boot status/control signals of bios_loader.
interface bios_loader_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 10
);
    logic                      start;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]     rom_q;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      busy;
    logic                      done;
    logic                      cpu_hold;

    modport master (
        input  start, rom_q,
        output rom_addr, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
    );

    modport slave (
        output start, rom_q,
        input  rom_addr, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
    );
endinterface

// File: rtl/bios_loader.sv
// Boot-time ROM-to-memory copier that holds the CPU in reset until the copy completes.
// Optional running sum of copied words enabled by defining BIOS_LOADER_CHECKSUM_EN.
module bios_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned LOAD_BASE      = 0,
    parameter int unsigned LOAD_WORDS     = 256
) (
    input  logic clk,
    input  logic rst,
    bios_loader_if.master bus
`ifdef BIOS_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam int unsigned RW = ROM_ADDR_WIDTH;
    localparam int unsigned MW = MEM_ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COPY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [RW-1:0] LAST = RW'(LOAD_WORDS - 1);
    localparam logic [MW-1:0] BASE = MW'(LOAD_BASE);

    logic [1:0]    state_q,     state_d;
    logic [RW-1:0] rom_addr_q,  rom_addr_d;
    logic          mem_we_q,    mem_we_d;
    logic [MW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          cpu_hold_q,  cpu_hold_d;

    // rom_addr doubles as the copy index; it never advances past the last word
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cpu_hold_d  = cpu_hold_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = COPY;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            COPY: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = BASE + MW'(rom_addr_q);
                mem_wdata_d = bus.rom_q;
                if (rom_addr_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + RW'(1);
                end
            end
            DRAIN: begin
                state_d    = DONE;
                mem_we_d   = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cpu_hold  = cpu_hold_q;

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    // Accumulates alongside each captured word; restarts with every new copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && bus.start) begin
            sum_q <= '0;
        end else if (state_q == COPY) begin
            sum_q <= sum_q + bus.rom_q;
        end
    end

    assign checksum = sum_q;
`endif
endmodule
